// File: rtl/alu_bsel_pkg.sv
// ---------------------------------------------------------------------------
// alu_bsel_pkg
// Shared definitions for the ALU B-operand select / forwarding block:
//   - B source select encodings (ALUB_RS2, ALUB_IMM1, ALUB_IMM2)
//   - default operand width, forwarding depth and register address width
//   - the operand data type and the output buffer state encoding
// ---------------------------------------------------------------------------
package alu_bsel_pkg;

    // B operand source select encodings; values above ALUB_IMM2 index
    // further immediate bus slots when NSRC is raised.
    localparam int ALUB_RS2  = 0;
    localparam int ALUB_IMM1 = 1;
    localparam int ALUB_IMM2 = 2;

    // Default geometry of the block.
    localparam int DEF_DW   = 32;
    localparam int DEF_NSRC = 4;
    localparam int DEF_NFWD = 2;
    localparam int DEF_AW   = 5;

    // Operand as seen by the ALU at the default width.
    typedef logic [DEF_DW-1:0] operand_t;

    // Output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu_bsel_fwd_match.sv
// ---------------------------------------------------------------------------
// alu_bsel_fwd_match
// Priority matcher that finds the youngest pipeline stage writing the
// register read on the rs2 port.
// Ports:
//   we       in  NFWD     per-stage register write enable
//   addr     in  NFWD*AW  per-stage destination register index
//   pend     in  NFWD     per-stage result not yet available (load)
//   rs2_addr in  AW       register index being read
//   hit      out 1        some stage matches
//   index    out IW       lowest matching stage index (youngest)
//   hit_pend out 1        pend flag of the winning stage
// ---------------------------------------------------------------------------
module alu_bsel_fwd_match #(
    parameter int NFWD = 2,
    parameter int AW   = 5,
    parameter int IW   = (NFWD > 1) ? $clog2(NFWD) : 1
) (
    input  logic [NFWD-1:0]    we,
    input  logic [NFWD*AW-1:0] addr,
    input  logic [NFWD-1:0]    pend,
    input  logic [AW-1:0]      rs2_addr,
    output logic               hit,
    output logic [IW-1:0]      index,
    output logic               hit_pend
);

    // Walk from the oldest stage down to the youngest so that a later
    // (lower index) match overwrites an earlier one: the youngest producer
    // always wins. Register 0 is hard-wired and never matches.
    always_comb begin
        hit      = 1'b0;
        index    = '0;
        hit_pend = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (we[i] && (addr[i*AW +: AW] == rs2_addr) && (rs2_addr != '0)) begin
                hit      = 1'b1;
                index    = IW'(i);
                hit_pend = pend[i];
            end
        end
    end

endmodule

// File: rtl/alu_bsel_fwd.sv
// ---------------------------------------------------------------------------
// alu_bsel_fwd
// Selects the ALU B operand from the register file, a forwarding stage or
// an immediate slot, detects load-use hazards, and registers the operand
// in a one-entry handshake buffer with full throughput.
// Configuration macro: ALU_BSEL_FWD_EN
//   defined   - results are forwarded from fwd_data, stall only on pending
//   undefined - fwd_data ignored, any match stalls until writeback
// Ports:
//   cpu_clk    in  1           clock, rising edge
//   cpu_rst_n  in  1           synchronous active-low reset
//   in_valid   in  1           upstream request valid
//   in_ready   out 1           request accepted this cycle
//   sel        in  SW          B source select
//   rs2_addr   in  AW          register behind rD2
//   rD2        in  DW          register file second read data
//   imm_bus    in  (NSRC-1)*DW immediates, slot k-1 serves sel=k
//   fwd_we     in  NFWD        stage writes a register
//   fwd_pend   in  NFWD        stage result not yet available
//   fwd_addr   in  NFWD*AW     stage destination register
//   fwd_data   in  NFWD*DW     stage result
//   out_valid  out 1           B holds a valid operand
//   out_ready  in  1           downstream accepts B
//   B          out DW          registered B operand
//   stall_cnt  out 16          saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module alu_bsel_fwd
    import alu_bsel_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NSRC = DEF_NSRC,
    parameter int NFWD = DEF_NFWD,
    parameter int AW   = DEF_AW,
    localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int IW  = (NFWD > 1) ? $clog2(NFWD) : 1
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SW-1:0]          sel,
    input  logic [AW-1:0]          rs2_addr,
    input  logic [DW-1:0]          rD2,
    input  logic [(NSRC-1)*DW-1:0] imm_bus,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD-1:0]        fwd_pend,
    input  logic [NFWD*AW-1:0]     fwd_addr,
    input  logic [NFWD*DW-1:0]     fwd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          B,
    output logic [15:0]            stall_cnt
);

    logic          hit;
    logic [IW-1:0] hit_index;
    logic          hit_pend;
    logic          is_rs2;
    logic          hazard;
    logic          transfer;
    logic [DW-1:0] next_b;
    buf_state_t    state;

    alu_bsel_fwd_match #(
        .NFWD (NFWD),
        .AW   (AW),
        .IW   (IW)
    ) u_match (
        .we       (fwd_we),
        .addr     (fwd_addr),
        .pend     (fwd_pend),
        .rs2_addr (rs2_addr),
        .hit      (hit),
        .index    (hit_index),
        .hit_pend (hit_pend)
    );

    assign is_rs2 = (sel == SW'(ALUB_RS2));

`ifdef ALU_BSEL_FWD_EN
    logic [DW-1:0] fwd_sel_data;

    // Pick the winning stage's result; only consulted when the matcher
    // reports a hit whose data is already available.
    always_comb begin
        fwd_sel_data = '0;
        for (int i = 0; i < NFWD; i++) begin
            if (hit_index == IW'(i)) begin
                fwd_sel_data = fwd_data[i*DW +: DW];
            end
        end
    end

    // Only a producer whose data is still in flight forces a stall.
    assign hazard = in_valid && is_rs2 && hit && hit_pend;
`else
    logic unused_fwd;

    // Without forwarding, any in-flight writer of rs2 stalls the request
    // until it has written back, so the data and pend paths go unused.
    assign hazard     = in_valid && is_rs2 && hit;
    assign unused_fwd = ^{fwd_data, hit_pend, hit_index};
`endif

    // Operand source mux. Selects outside the populated immediate slots
    // yield zero so an out-of-range select can never leak stale data.
    always_comb begin
        next_b = '0;
        if (is_rs2) begin
`ifdef ALU_BSEL_FWD_EN
            next_b = (hit && !hit_pend) ? fwd_sel_data : rD2;
`else
            next_b = rD2;
`endif
        end else begin
            for (int k = 1; k < NSRC; k++) begin
                if (sel == SW'(k)) begin
                    next_b = imm_bus[(k-1)*DW +: DW];
                end
            end
        end
    end

    // A request is accepted when the buffer is free or draining this same
    // cycle, no hazard is pending, and the block is out of reset so that
    // nothing is accepted into a buffer that reset is about to clear.
    assign in_ready = cpu_rst_n && ((state == BUF_EMPTY) || out_ready) && !hazard;
    assign transfer = in_valid && in_ready;

    // One-entry output buffer. A transfer always (re)fills it, which gives
    // back-to-back throughput when draining and loading coincide; otherwise
    // a drain empties it and a stalled consumer keeps B frozen.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
            B         <= '0;
        end else begin
            if (transfer) begin
                state     <= BUF_FULL;
                out_valid <= 1'b1;
                B         <= next_b;
            end else if ((state == BUF_FULL) && out_ready) begin
                state     <= BUF_EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

    // Count stalled cycles for performance monitoring, sticking at the
    // maximum rather than wrapping back to small values.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
